// File: rtl/exclusive_max_n.sv
// N-input exclusive-max for race-logic datapaths: a pulse fires at the latest arrival
// in a gamma window only when that arrival is unique; ties and missing inputs yield null.
module exclusive_max_n #(
    parameter int NUM_INPUTS        = 4,
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8
) (
    input  logic                                 aclk,
    input  logic                                 grst,
    input  logic                                 gamma_start,
    input  logic [NUM_INPUTS-1:0]                in,
    output logic                                 q,
    output logic                                 out_valid,
    output logic                                 out_null,
    output logic [$clog2(GAMMA_CYCLE_WIDTH)-1:0] out_time
);

    localparam int TW  = $clog2(GAMMA_CYCLE_WIDTH);
    localparam int GW  = TW + 1;
    localparam int PCW = $clog2(PULSE_WIDTH + 1);

    localparam logic [GW-1:0]  LAST_CNT  = GW'(GAMMA_CYCLE_WIDTH - 1);
    localparam logic [GW-1:0]  GCNT_MAX  = '1;
    localparam logic [PCW-1:0] PULSE_LEN = PCW'(PULSE_WIDTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t                r_state;
    logic [NUM_INPUTS-1:0] r_arrived;
    logic [GW-1:0]         r_gcnt;
    logic [PCW-1:0]        r_pcnt;
    logic                  r_out_valid;
    logic                  r_out_null;
    logic [TW-1:0]         r_out_time;

    state_t                w_next_state;
    logic [NUM_INPUTS-1:0] w_next_arrived;
    logic [GW-1:0]         w_next_gcnt;
    logic [PCW-1:0]        w_next_pcnt;
    logic                  w_next_out_valid;
    logic                  w_next_out_null;
    logic [TW-1:0]         w_next_out_time;

    logic [NUM_INPUTS-1:0] w_new;
    logic                  w_all;
    logic                  w_was_all;
    logic                  w_single;
    logic                  w_multi;

    // Arrival classification: a channel counts only on its first high sample in the window.
    always_comb begin
        w_new     = in & ~r_arrived;
        w_all     = &(r_arrived | w_new);
        w_was_all = &r_arrived;
        w_single  = (w_new != '0) && ((w_new & (w_new - NUM_INPUTS'(1))) == '0);
        w_multi   = (w_new != '0) && !w_single;
    end

    always_comb begin
        // NOTE: every next-state signal gets a default before any branch so no latch is inferred.
        w_next_state     = r_state;
        w_next_arrived   = r_arrived;
        w_next_gcnt      = r_gcnt;
        w_next_out_valid = 1'b0;
        w_next_out_null  = r_out_null;
        w_next_out_time  = r_out_time;
        w_next_pcnt      = (r_pcnt != '0) ? r_pcnt - PCW'(1) : '0;

        if (gamma_start) begin
            w_next_state   = COLLECT;
            w_next_arrived = '0;
            w_next_gcnt    = '0;
        end else begin
            case (r_state)
                COLLECT: begin
                    w_next_arrived = r_arrived | w_new;
                    w_next_gcnt    = (r_gcnt == GCNT_MAX) ? r_gcnt : r_gcnt + GW'(1);
                    if (w_all && !w_was_all && w_single) begin
                        w_next_state     = DONE;
                        w_next_out_valid = 1'b1;
                        w_next_out_null  = 1'b0;
                        w_next_out_time  = r_gcnt[TW-1:0];
                        w_next_pcnt      = PULSE_LEN;
                    end else if (w_all && w_multi) begin
                        w_next_state     = DONE;
                        w_next_out_valid = 1'b1;
                        w_next_out_null  = 1'b1;
                    end else if (r_gcnt == LAST_CNT) begin
                        w_next_state     = DONE;
                        w_next_out_valid = 1'b1;
                        w_next_out_null  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge aclk) begin
        if (grst) begin
            r_state     <= IDLE;
            r_arrived   <= '0;
            r_gcnt      <= '0;
            r_pcnt      <= '0;
            r_out_valid <= 1'b0;
            r_out_null  <= 1'b0;
            r_out_time  <= '0;
        end else begin
            r_state     <= w_next_state;
            r_arrived   <= w_next_arrived;
            r_gcnt      <= w_next_gcnt;
            r_pcnt      <= w_next_pcnt;
            r_out_valid <= w_next_out_valid;
            r_out_null  <= w_next_out_null;
            r_out_time  <= w_next_out_time;
        end
    end

    assign q         = (r_pcnt != '0);
    assign out_valid = r_out_valid;
    assign out_null  = r_out_null;
    assign out_time  = r_out_time;

endmodule

// File: tb/tb_exclusive_max_n.sv
// Directed bench for exclusive_max_n: table-driven windows on a 4-input instance plus
// hand sequences for reset, abort/race, re-rise, and a 2-input pulse-reload case.
module tb_exclusive_max_n;

    localparam int G  = 16;
    localparam int PW = 8;

    logic       aclk = 1'b0;
    logic       grst;
    logic       gs4;
    logic [3:0] in4;
    logic       q4, ov4, on4;
    logic [3:0] ot4;
    logic       gs2;
    logic [1:0] in2;
    logic       q2, ov2, on2;
    logic [3:0] ot2;

    int n_checks = 0;
    int n_err    = 0;

    always #5 aclk = ~aclk;

    exclusive_max_n #(.NUM_INPUTS(4), .GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(PW)) u_dut4 (
        .aclk(aclk), .grst(grst), .gamma_start(gs4), .in(in4),
        .q(q4), .out_valid(ov4), .out_null(on4), .out_time(ot4)
    );

    exclusive_max_n #(.NUM_INPUTS(2), .GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(PW)) u_dut2 (
        .aclk(aclk), .grst(grst), .gamma_start(gs2), .in(in2),
        .q(q2), .out_valid(ov2), .out_null(on2), .out_time(ot2)
    );

    typedef struct {
        string name;
        int    t0, t1, t2, t3;
        int    exp_edge;
        int    exp_null;
        int    exp_time;
    } vec_t;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input string n, input int a, input int b, input int c,
                                input int d, input int e, input int nl, input int tm);
        vec_t v;
        v.name = n; v.t0 = a; v.t1 = b; v.t2 = c; v.t3 = d;
        v.exp_edge = e; v.exp_null = nl; v.exp_time = tm;
        return v;
    endfunction

    // One full window on the 4-input instance; arrival time -1 means never.
    task automatic run_win4(input vec_t v);
        int t[4];
        int v_cnt = 0, v_edge = -1, v_null = -1, v_time = -1;
        int q_cnt = 0, q_first = -1;
        t[0] = v.t0; t[1] = v.t1; t[2] = v.t2; t[3] = v.t3;
        gs4 = 1'b1;
        for (int ch = 0; ch < 4; ch++) in4[ch] = (t[ch] == 0);
        tick();
        gs4 = 1'b0;
        for (int c = 0; c < G + PW + 2; c++) begin
            for (int ch = 0; ch < 4; ch++) in4[ch] = (t[ch] >= 0) && (c >= t[ch]);
            tick();
            if (ov4) begin
                v_cnt++;
                if (v_edge < 0) begin
                    v_edge = c + 1;
                    v_null = int'(on4);
                    v_time = int'(ot4);
                end
            end
            if (q4) begin
                q_cnt++;
                if (q_first < 0) q_first = c + 1;
            end
        end
        in4 = '0;
        check({v.name, " valid_count"}, v_cnt, 1);
        check({v.name, " valid_edge"}, v_edge, v.exp_edge);
        check({v.name, " null"}, v_null, v.exp_null);
        if (v.exp_null == 0) begin
            check({v.name, " time"}, v_time, v.exp_time);
            check({v.name, " q_start"}, q_first, v.exp_edge);
        end
        check({v.name, " q_cycles"}, q_cnt, (v.exp_null != 0) ? 0 : PW);
    endtask

    initial begin
        vec_t vecs[6];
        int   cnt;
        int   qc;

        vecs[0] = mk("unique_max",   2, 5,  5, 9, 10, 0, 9);
        vecs[1] = mk("tie_at_max",   1, 7,  3, 7,  8, 1, 0);
        vecs[2] = mk("missing_ch2",  1, 2, 20, 4, 16, 1, 0);
        vecs[3] = mk("all_at_zero",  0, 0,  0, 0,  1, 1, 0);
        vecs[4] = mk("fire_at_last", 0, 3, 15, 6, 16, 0, 15);
        vecs[5] = mk("fire_at_one",  0, 0,  0, 1,  2, 0, 1);

        // Reset with inputs high; IDLE must ignore them.
        grst = 1'b1; gs4 = 1'b0; gs2 = 1'b0; in4 = 4'b1111; in2 = 2'b11;
        tick(); tick();
        check("reset q", int'(q4), 0);
        check("reset out_valid", int'(ov4), 0);
        check("reset out_null", int'(on4), 0);
        check("reset out_time", int'(ot4), 0);
        grst = 1'b0;
        cnt = 0; qc = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            cnt += int'(ov4) + int'(ov2);
            qc  += int'(q4) + int'(q2);
        end
        check("idle out_valid count", cnt, 0);
        check("idle q count", qc, 0);
        in4 = '0; in2 = '0;

        for (int i = 0; i < 6; i++) run_win4(vecs[i]);

        // Abort a window; the new gamma_start races a ch3 rise which is discarded.
        cnt = 0;
        gs4 = 1'b1; in4 = '0; tick(); gs4 = 1'b0;
        in4 = 4'b0000; tick(); cnt += int'(ov4);
        in4 = 4'b0001; tick(); cnt += int'(ov4);
        in4 = 4'b0011; tick(); cnt += int'(ov4);
        gs4 = 1'b1; in4 = 4'b1011; tick(); cnt += int'(ov4);
        gs4 = 1'b0;
        for (int c = 0; c < 7; c++) begin
            in4 = 4'b1000 | ((c >= 3) ? 4'b0011 : 4'b0000) | ((c >= 6) ? 4'b0100 : 4'b0000);
            tick();
            if (c < 6) cnt += int'(ov4);
        end
        check("abort no early valid", cnt, 0);
        check("abort valid", int'(ov4), 1);
        check("abort null", int'(on4), 0);
        check("abort time", int'(ot4), 6);
        check("abort q", int'(q4), 1);
        in4 = '0;
        for (int c = 0; c < PW + 2; c++) tick();

        // Rise-fall-rise on ch0 coincides with ch3's arrival; only ch3 is new.
        cnt = 0;
        gs4 = 1'b1; tick(); gs4 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            in4[0] = (c == 1) || (c >= 5);
            in4[1] = (c >= 3);
            in4[2] = (c >= 4);
            in4[3] = (c >= 5);
            tick();
            if (c < 5) cnt += int'(ov4);
        end
        check("rerise no early valid", cnt, 0);
        check("rerise valid", int'(ov4), 1);
        check("rerise null", int'(on4), 0);
        check("rerise time", int'(ot4), 5);
        in4 = '0;
        for (int c = 0; c < PW + 2; c++) tick();

        // N=2: tie at 0, then a@3 b@4, then back-to-back window firing during the pulse.
        gs2 = 1'b1; in2 = 2'b11; tick(); gs2 = 1'b0;
        in2 = 2'b11; tick();
        check("n2 tie valid", int'(ov2), 1);
        check("n2 tie null", int'(on2), 1);
        check("n2 tie q", int'(q2), 0);
        gs2 = 1'b1; in2 = 2'b00; tick(); gs2 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in2 = {c >= 4, c >= 3};
            tick();
        end
        check("n2 fire valid", int'(ov2), 1);
        check("n2 fire null", int'(on2), 0);
        check("n2 fire time", int'(ot2), 4);
        qc = int'(q2);
        gs2 = 1'b1; in2 = 2'b00; tick(); gs2 = 1'b0; qc += int'(q2);
        in2 = 2'b01; tick(); qc += int'(q2);
        in2 = 2'b11; tick(); qc += int'(q2);
        check("n2 reload valid", int'(ov2), 1);
        check("n2 reload time", int'(ot2), 1);
        for (int c = 0; c < 12; c++) begin
            tick();
            qc += int'(q2);
        end
        check("n2 reload q cycles", qc, 11);
        in2 = '0;

        // Mid-run reset clears a live pulse and the held result.
        gs4 = 1'b1; in4 = 4'b0111; tick(); gs4 = 1'b0;
        in4 = 4'b0111; tick();
        in4 = 4'b1111; tick();
        check("prereset time", int'(ot4), 1);
        grst = 1'b1; tick(); grst = 1'b0;
        check("midreset q", int'(q4), 0);
        check("midreset out_time", int'(ot4), 0);
        check("midreset out_valid", int'(ov4), 0);
        in4 = '0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
